spio_rr_arbiter_n: RTL and testbench

- N-input packet arbiter merging NUM_PORTS valid/ready packet streams into one registered output stream.
- Each input has a one-entry parking register, so an input never stalls combinationally on the output.
- Successor to the two-input arbiter. Adds parametrised port count, a selectable fixed-priority mode, and a source-index output.
- Used in the router/switch fabric wherever several packet sources share one link.

---
 rtl/spio_rr_arbiter_n.sv | 175 +++++++++++++++++
 tb/tb_spio_rr_arbiter_n.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spio_rr_arbiter_n.sv
// spio_rr_arbiter_n: merges NUM_PORTS valid/ready packet streams onto one
// registered output link. Each input owns a one-entry parking register so an
// input never depends combinationally on downstream ready. Arbitration is
// round-robin from a rotating pointer, or fixed lowest-index-wins priority.
// NUM_PORTS is legal from 2 to 16; SRC_BITS must cover ceil(log2(NUM_PORTS)).
module spio_rr_arbiter_n #(
  parameter int PKT_BITS   = 72,
  parameter int NUM_PORTS  = 4,
  parameter int SRC_BITS   = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                          CLK_IN,
  input  logic                          RESET_IN,
  input  logic [NUM_PORTS*PKT_BITS-1:0] DATA_IN,
  input  logic [NUM_PORTS-1:0]          VLD_IN,
  output logic [NUM_PORTS-1:0]          RDY_OUT,
  output logic [PKT_BITS-1:0]           DATA_OUT,
  output logic                          VLD_OUT,
  output logic [SRC_BITS-1:0]           SRC_OUT,
  input  logic                          RDY_IN
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PARKED = 1'b1
  } port_st_e;

  // Per-input state and parking storage
  port_st_e            st_q   [NUM_PORTS];
  port_st_e            st_d   [NUM_PORTS];
  logic [PKT_BITS-1:0] park_q [NUM_PORTS];
  logic [PKT_BITS-1:0] park_d [NUM_PORTS];

  // Effective request view: parked packet takes precedence over the live input
  logic [NUM_PORTS-1:0] eff_vld_s;
  logic [PKT_BITS-1:0]  eff_data_s [NUM_PORTS];

  // Arbitration
  logic [SRC_BITS-1:0]  ptr_q;
  logic [SRC_BITS-1:0]  ptr_d;
  logic [SRC_BITS-1:0]  gnt_idx_s;
  logic                 gnt_vld_s;
  logic                 can_send_s;
  logic                 load_s;
  logic [NUM_PORTS-1:0] sel_s;

  // Output register
  logic [PKT_BITS-1:0]  data_q;
  logic [PKT_BITS-1:0]  data_d;
  logic                 vld_q;
  logic                 vld_d;
  logic [SRC_BITS-1:0]  src_q;
  logic [SRC_BITS-1:0]  src_d;

  // Build the effective valid/data seen by the arbiter for every input
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      eff_vld_s[i]  = (st_q[i] == ST_PARKED) ? 1'b1 : VLD_IN[i];
      eff_data_s[i] = (st_q[i] == ST_PARKED) ? park_q[i]
                                             : DATA_IN[i*PKT_BITS +: PKT_BITS];
    end
  end

  // Select the winning input: scan upward from ptr (or from 0 in fixed mode)
  always_comb begin
    int                  sum;
    logic [SRC_BITS-1:0] idx;
    logic                hit;
    sum       = 0;
    idx       = '0;
    hit       = 1'b0;
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum       = (FIXED_PRIO != 0) ? k : (int'(ptr_q) + k);
      idx       = (sum >= NUM_PORTS) ? SRC_BITS'(sum - NUM_PORTS) : SRC_BITS'(sum);
      hit       = !gnt_vld_s && eff_vld_s[idx];
      gnt_idx_s = hit ? idx : gnt_idx_s;
      gnt_vld_s = gnt_vld_s | hit;
    end
  end

  // The output register can take a new packet when empty or draining this cycle
  always_comb begin
    can_send_s = !vld_q || RDY_IN;
    load_s     = can_send_s && gnt_vld_s;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_s[i] = load_s && (gnt_idx_s == SRC_BITS'(i));
    end
  end

  // Per-input next state: park an unserved arrival, release on its own grant
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      st_d[i]   = st_q[i];
      park_d[i] = park_q[i];
      case (st_q[i])
        ST_RUN: begin
          if (VLD_IN[i] && !sel_s[i]) begin
            st_d[i]   = ST_PARKED;
            park_d[i] = DATA_IN[i*PKT_BITS +: PKT_BITS];
          end else begin
            st_d[i]   = ST_RUN;
          end
        end
        ST_PARKED: begin
          if (sel_s[i]) begin
            st_d[i] = ST_RUN;
          end else begin
            st_d[i] = ST_PARKED;
          end
        end
        default: begin
          st_d[i] = ST_RUN;
        end
      endcase
    end
  end

  // Output register and pointer next state; pointer moves only on a load
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    src_d  = src_q;
    ptr_d  = ptr_q;
    if (can_send_s) begin
      vld_d = gnt_vld_s;
      if (gnt_vld_s) begin
        data_d = eff_data_s[gnt_idx_s];
        src_d  = gnt_idx_s;
        ptr_d  = (gnt_idx_s == SRC_BITS'(NUM_PORTS - 1)) ? '0
                                                         : gnt_idx_s + SRC_BITS'(1);
      end else begin
        data_d = data_q;
        src_d  = src_q;
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // State, parking, output and pointer registers with asynchronous reset
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        st_q[i]   <= ST_RUN;
        park_q[i] <= '0;
      end
      vld_q  <= 1'b0;
      data_q <= '0;
      src_q  <= '0;
      ptr_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        st_q[i]   <= st_d[i];
        park_q[i] <= park_d[i];
      end
      vld_q  <= vld_d;
      data_q <= data_d;
      src_q  <= src_d;
      ptr_q  <= ptr_d;
    end
  end

  // Drive ports: ready is a pure decode of the per-input state register
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      RDY_OUT[i] = (st_q[i] == ST_RUN);
    end
    DATA_OUT = data_q;
    VLD_OUT  = vld_q;
    SRC_OUT  = src_q;
  end

endmodule

// File: tb/tb_spio_rr_arbiter_n.sv
// Directed bench for spio_rr_arbiter_n: one round-robin instance and one
// fixed-priority instance, 4 ports of 8-bit packets, hand-computed expectations.
module tb_spio_rr_arbiter_n;

  logic        clk;
  logic        rst;

  logic [31:0] rr_data;
  logic [3:0]  rr_vld;
  logic [3:0]  rr_rdy_out;
  logic [7:0]  rr_dout;
  logic        rr_vout;
  logic [1:0]  rr_src;
  logic        rr_rdy_in;

  logic [31:0] fp_data;
  logic [3:0]  fp_vld;
  logic [3:0]  fp_rdy_out;
  logic [7:0]  fp_dout;
  logic        fp_vout;
  logic [1:0]  fp_src;
  logic        fp_rdy_in;

  int n_checks;
  int n_errors;

  spio_rr_arbiter_n #(.PKT_BITS(8), .NUM_PORTS(4), .SRC_BITS(2), .FIXED_PRIO(0)) dut_rr (
    .CLK_IN(clk), .RESET_IN(rst), .DATA_IN(rr_data), .VLD_IN(rr_vld),
    .RDY_OUT(rr_rdy_out), .DATA_OUT(rr_dout), .VLD_OUT(rr_vout),
    .SRC_OUT(rr_src), .RDY_IN(rr_rdy_in)
  );

  spio_rr_arbiter_n #(.PKT_BITS(8), .NUM_PORTS(4), .SRC_BITS(2), .FIXED_PRIO(1)) dut_fp (
    .CLK_IN(clk), .RESET_IN(rst), .DATA_IN(fp_data), .VLD_IN(fp_vld),
    .RDY_OUT(fp_rdy_out), .DATA_OUT(fp_dout), .VLD_OUT(fp_vout),
    .SRC_OUT(fp_src), .RDY_IN(fp_rdy_in)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ss  [3];
    logic [3:0] drn [3];
    int         e;
    ss[0] = 8'h11; ss[1] = 8'h22; ss[2] = 8'h33;
    drn[0] = 4'b0011; drn[1] = 4'b0111; drn[2] = 4'b1111;
    n_checks  = 0;
    n_errors  = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    rr_data   = 32'd0;
    rr_vld    = 4'd0;
    rr_rdy_in = 1'b1;
    fp_data   = 32'd0;
    fp_vld    = 4'd0;
    fp_rdy_in = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld",    32'(rr_vout),    32'd0);
    check("rst_data",   32'(rr_dout),    32'd0);
    check("rst_src",    32'(rr_src),     32'd0);
    check("rst_rdy",    32'(rr_rdy_out), 32'hF);
    check("rst_rdy_fp", 32'(fp_rdy_out), 32'hF);
    rst = 1'b0;

    // Single stream on port 2
    rr_vld = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      rr_data[2*8 +: 8] = ss[k];
      step();
      check("ss_data", 32'(rr_dout),    32'(ss[k]));
      check("ss_src",  32'(rr_src),     32'd2);
      check("ss_vld",  32'(rr_vout),    32'd1);
      check("ss_rdy",  32'(rr_rdy_out), 32'hF);
    end
    rr_vld = 4'd0;
    step();
    check("ss_idle_vld",  32'(rr_vout), 32'd0);
    check("ss_idle_hold", 32'(rr_dout), 32'h33);

    // Wrap-around: ptr=3, ports 0 and 3 valid
    rr_vld = 4'b1001;
    rr_data[0*8 +: 8] = 8'hC0;
    rr_data[3*8 +: 8] = 8'hC3;
    step();
    rr_vld = 4'd0;
    check("wrap_src0",  32'(rr_src),     32'd3);
    check("wrap_data0", 32'(rr_dout),    32'hC3);
    check("wrap_rdy0",  32'(rr_rdy_out), 32'hE);
    step();
    check("wrap_src1",  32'(rr_src),     32'd0);
    check("wrap_data1", 32'(rr_dout),    32'hC0);
    check("wrap_rdy1",  32'(rr_rdy_out), 32'hF);
    // ptr is now 1: ports 0 and 1 valid must pick 1 first
    rr_vld = 4'b0011;
    rr_data[0*8 +: 8] = 8'hD0;
    rr_data[1*8 +: 8] = 8'hD1;
    step();
    rr_vld = 4'd0;
    check("ptr1_src",  32'(rr_src),     32'd1);
    check("ptr1_data", 32'(rr_dout),    32'hD1);
    check("ptr1_rdy",  32'(rr_rdy_out), 32'hE);
    step();
    check("ptr1_src2",  32'(rr_src),  32'd0);
    check("ptr1_data2", 32'(rr_dout), 32'hD0);
    step();
    check("ptr1_idle", 32'(rr_vout), 32'd0);
    check("ptr1_hold", 32'(rr_dout), 32'hD0);

    // Round-robin fairness, ptr starts at 1
    for (int i = 0; i < 4; i++) rr_data[i*8 +: 8] = 8'hA0 + 8'(i);
    rr_vld = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step();
      e = (1 + k) % 4;
      check("rr_src",  32'(rr_src),     32'(e));
      check("rr_data", 32'(rr_dout),    32'(8'hA0 + 8'(e)));
      check("rr_vld",  32'(rr_vout),    32'd1);
      check("rr_rdy",  32'(rr_rdy_out), 32'(4'b0001 << e));
    end
    rr_vld = 4'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("drain_src",  32'(rr_src),     32'(k + 1));
      check("drain_data", 32'(rr_dout),    32'(8'hA1 + 8'(k)));
      check("drain_rdy",  32'(rr_rdy_out), 32'(drn[k]));
    end
    step();
    check("drain_idle", 32'(rr_vout), 32'd0);

    // Backpressure: ptr=0, ports 0 and 3 each offer one packet
    rr_rdy_in = 1'b0;
    rr_vld    = 4'b1001;
    rr_data[0*8 +: 8] = 8'h55;
    rr_data[3*8 +: 8] = 8'h66;
    step();
    rr_vld = 4'd0;
    check("bp_vld",  32'(rr_vout),    32'd1);
    check("bp_data", 32'(rr_dout),    32'h55);
    check("bp_src",  32'(rr_src),     32'd0);
    check("bp_rdy",  32'(rr_rdy_out), 32'h7);
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_hold_vld",  32'(rr_vout),    32'd1);
      check("bp_hold_data", 32'(rr_dout),    32'h55);
      check("bp_hold_src",  32'(rr_src),     32'd0);
      check("bp_hold_rdy",  32'(rr_rdy_out), 32'h7);
    end
    rr_rdy_in = 1'b1;
    step();
    check("bp_rel_data", 32'(rr_dout),    32'h66);
    check("bp_rel_src",  32'(rr_src),     32'd3);
    check("bp_rel_vld",  32'(rr_vout),    32'd1);
    check("bp_rel_rdy",  32'(rr_rdy_out), 32'hF);
    step();
    check("bp_idle", 32'(rr_vout), 32'd0);

    // Fixed priority: ports 1 and 3 continuously valid
    fp_vld = 4'b1010;
    fp_data[1*8 +: 8] = 8'h71;
    fp_data[3*8 +: 8] = 8'h73;
    for (int k = 0; k < 4; k++) begin
      step();
      check("fp_src",  32'(fp_src),     32'd1);
      check("fp_data", 32'(fp_dout),    32'h71);
      check("fp_rdy",  32'(fp_rdy_out), 32'h7);
    end
    fp_vld = 4'd0;
    step();
    check("fp_p3_src",  32'(fp_src),     32'd3);
    check("fp_p3_data", 32'(fp_dout),    32'h73);
    check("fp_p3_rdy",  32'(fp_rdy_out), 32'hF);
    step();
    check("fp_idle", 32'(fp_vout), 32'd0);

    // Reset mid-stream with output held and two ports parked
    rr_rdy_in = 1'b0;
    rr_vld    = 4'b0111;
    rr_data[0*8 +: 8] = 8'h90;
    rr_data[1*8 +: 8] = 8'h91;
    rr_data[2*8 +: 8] = 8'h92;
    step();
    rr_vld = 4'd0;
    check("mid_vld",  32'(rr_vout),    32'd1);
    check("mid_data", 32'(rr_dout),    32'h90);
    check("mid_rdy",  32'(rr_rdy_out), 32'h9);
    rst = 1'b1;
    #2;
    check("arst_vld",  32'(rr_vout),    32'd0);
    check("arst_src",  32'(rr_src),     32'd0);
    check("arst_data", 32'(rr_dout),    32'd0);
    check("arst_rdy",  32'(rr_rdy_out), 32'hF);
    step();
    rst       = 1'b0;
    rr_rdy_in = 1'b1;
    step();
    check("post_rst_idle0", 32'(rr_vout), 32'd0);
    step();
    check("post_rst_idle1", 32'(rr_vout), 32'd0);
    // Pointer must be back at 0: ports 0 and 3 pick 0 first
    rr_vld = 4'b1001;
    rr_data[0*8 +: 8] = 8'hB0;
    rr_data[3*8 +: 8] = 8'hB3;
    step();
    rr_vld = 4'd0;
    check("post_rst_src0",  32'(rr_src),  32'd0);
    check("post_rst_data0", 32'(rr_dout), 32'hB0);
    step();
    check("post_rst_src1",  32'(rr_src),  32'd3);
    check("post_rst_data1", 32'(rr_dout), 32'hB3);
    step();
    check("post_rst_end", 32'(rr_vout), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
